// File: rtl/req_delay_line.sv
// rtl/req_delay_line.sv - runtime-programmable multi-channel delay line for 2-phase request signals
// Each channel shifts inR through a MAX_DELAY-deep register and taps it at the programmed delay.
module req_delay_line #(
  parameter int CH            = 4,
  parameter int MAX_DELAY     = 16,
  parameter int DEFAULT_DELAY = 5,
  parameter int CHW           = (CH > 1) ? $clog2(CH) : 1,
  parameter int DW            = $clog2(MAX_DELAY + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] inR,
  output logic [CH-1:0] outR,
  input  logic          cfg_valid,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [DW-1:0] cfg_delay,
  output logic          cfg_ready,
  output logic [CH-1:0] busy
);

  localparam int IW = $clog2(MAX_DELAY);

  logic [MAX_DELAY-1:0] sr_q [CH];
  logic [MAX_DELAY-1:0] sr_d [CH];
  logic [DW-1:0]        d_q  [CH];
  logic [DW-1:0]        d_d  [CH];

  logic [DW-1:0] delay_clamped;
  logic [CHW:0]  cfg_ch_ext;
  logic [IW-1:0] tap_idx;
  logic          sel_busy;
  logic          cfg_fire;

  always_comb begin
    delay_clamped = cfg_delay;
    cfg_ch_ext    = {1'b0, cfg_ch};
    tap_idx       = '0;
    sel_busy      = 1'b0;
    outR          = '0;
    busy          = '0;

    if (cfg_delay == '0) begin
      delay_clamped = DW'(1);
    end else if (cfg_delay > DW'(MAX_DELAY)) begin
      delay_clamped = DW'(MAX_DELAY);
    end

    for (int c = 0; c < CH; c++) begin
      // a channel is idle only when every stage holds the same level
      busy[c]    = !((&sr_q[c]) || !(|sr_q[c]));
      tap_idx    = IW'(d_q[c] - DW'(1));
      outR[c]    = sr_q[c][tap_idx];
      sr_d[c]    = {sr_q[c][MAX_DELAY-2:0], inR[c]};
      if (cfg_ch_ext == (CHW+1)'(c)) begin
        sel_busy = busy[c];
      end
    end

    // out-of-range channels never match, so their writes are accepted and dropped
    cfg_ready = !rst && !sel_busy;
    cfg_fire  = cfg_valid && cfg_ready;

    for (int c = 0; c < CH; c++) begin
      d_d[c] = d_q[c];
      if (cfg_fire && (cfg_ch_ext == (CHW+1)'(c))) begin
        d_d[c] = delay_clamped;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        sr_q[c] <= '0;
        d_q[c]  <= DW'(DEFAULT_DELAY);
      end
    end else begin
      for (int c = 0; c < CH; c++) begin
        sr_q[c] <= sr_d[c];
        d_q[c]  <= d_d[c];
      end
    end
  end

endmodule

// File: tb/tb_req_delay_line.sv
// tb/tb_req_delay_line.sv - scoreboard bench for req_delay_line
// Expected output transitions are queued per channel when inputs change and popped as outR moves.
module tb_req_delay_line;

  localparam int MAXD = 16;
  localparam int DEFD = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] inR = '0;
  logic [3:0] outR;
  logic [3:0] busy;
  logic       cfg_valid = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [4:0] cfg_delay = '0;
  logic       cfg_ready;

  logic [2:0] inR3 = '0;
  logic [2:0] outR3;
  logic [2:0] busy3;
  logic       cfg_valid3 = 1'b0;
  logic [1:0] cfg_ch3 = '0;
  logic [4:0] cfg_delay3 = '0;
  logic       cfg_ready3;

  typedef struct {
    int   at;
    logic val;
  } exp_t;

  exp_t       exp_q [4][$];
  int         model_d [4];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  logic [3:0] prev_out = '0;
  bit         mon_en = 1'b1;

  req_delay_line u_dut (
    .clk(clk), .rst(rst), .inR(inR), .outR(outR),
    .cfg_valid(cfg_valid), .cfg_ch(cfg_ch), .cfg_delay(cfg_delay),
    .cfg_ready(cfg_ready), .busy(busy)
  );

  req_delay_line #(.CH(3)) u_dut3 (
    .clk(clk), .rst(rst), .inR(inR3), .outR(outR3),
    .cfg_valid(cfg_valid3), .cfg_ch(cfg_ch3), .cfg_delay(cfg_delay3),
    .cfg_ready(cfg_ready3), .busy(busy3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard monitor, sampled shortly after each rising edge
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (!mon_en) begin
      prev_out = outR;
    end else begin
      for (int c = 0; c < 4; c++) begin
        if (exp_q[c].size() != 0 && exp_q[c][0].at < cyc) begin
          total++;
          bad++;
          $display("FAIL sb_missed ch%0d: no change by edge %0d, required %b at edge %0d",
                   c, cyc, exp_q[c][0].val, exp_q[c][0].at);
          void'(exp_q[c].pop_front());
        end
        if (outR[c] !== prev_out[c]) begin
          total++;
          if (exp_q[c].size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected ch%0d: outR=%b at edge %0d, required no change", c, outR[c], cyc);
          end else begin
            e = exp_q[c].pop_front();
            if (e.at != cyc || e.val !== outR[c]) begin
              bad++;
              $display("FAIL sb_transition ch%0d: got %b at edge %0d, required %b at edge %0d",
                       c, outR[c], cyc, e.val, e.at);
            end
          end
        end
      end
      prev_out = outR;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_in(input logic [3:0] v);
    exp_t e;
    for (int c = 0; c < 4; c++) begin
      if (v[c] !== inR[c]) begin
        e.at  = cyc + model_d[c];
        e.val = v[c];
        exp_q[c].push_back(e);
      end
    end
    inR = v;
  endtask

  task automatic cfg_write(input int ch, input int dly, input int exp_d);
    cfg_valid = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_delay = 5'(dly);
    #1;
    total++;
    if (cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL cfg_ready_idle ch%0d: got %b, required 1", ch, cfg_ready);
    end
    model_d[ch] = exp_d;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int n;
    int pending;
    n = 0;
    pending = exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size();
    while (pending != 0 && n < 60) begin
      tick();
      n++;
      pending = exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size();
    end
    total++;
    if (pending != 0) begin
      bad++;
      $display("FAIL %s_drain: %0d transitions still pending, required 0", nm, pending);
    end
  endtask

  task automatic wait_idle(input string nm);
    repeat (MAXD + 1) tick();
    total++;
    if (busy !== 4'b0000) begin
      bad++;
      $display("FAIL %s_idle: busy=%b, required 0000", nm, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    inR = '0;
    cfg_ch = '0;
    tick();
    tick();
    total++;
    if (cfg_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_cfg_ready: got %b, required 0", cfg_ready);
    end
    total++;
    if (outR !== 4'b0000) begin
      bad++;
      $display("FAIL reset_outR: got %b, required 0000", outR);
    end
    total++;
    if (busy !== 4'b0000) begin
      bad++;
      $display("FAIL reset_busy: got %b, required 0000", busy);
    end
    rst = 1'b0;
    #1;
    total++;
    if (cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_cfg_ready: got %b, required 1", cfg_ready);
    end
    repeat (7) tick();
    set_in(4'b0001);
    wait_drain("reset");
    wait_idle("reset");
  endtask

  task automatic test_program();
    cfg_write(2, 1, 1);
    cfg_write(3, 31, MAXD);
    cfg_write(1, 0, 1);
    set_in(~inR);
    tick();
    total++;
    if (busy !== 4'b1111) begin
      bad++;
      $display("FAIL program_busy: got %b, required 1111", busy);
    end
    wait_drain("program");
    wait_idle("program");
  endtask

  task automatic test_back_to_back();
    int   e;
    logic exp_b;
    cfg_write(0, 5, 5);
    e = cyc + 1;
    set_in(inR | 4'b0001);
    tick();
    set_in(inR & 4'b1110);
    tick();
    tick();
    set_in(inR | 4'b0001);
    tick();
    while (cyc <= e + 20) begin
      exp_b = (cyc <= e + 17);
      total++;
      if (busy[0] !== exp_b) begin
        bad++;
        $display("FAIL b2b_busy edge %0d: got %b, required %b", cyc, busy[0], exp_b);
      end
      tick();
    end
    wait_drain("b2b");
    wait_idle("b2b");
  endtask

  task automatic test_blocked();
    int   e;
    int   n;
    logic exp_r;
    e = cyc + 1;
    set_in(inR & 4'b1110);
    tick();
    cfg_write(1, 4, 4);
    cfg_valid = 1'b1;
    cfg_ch    = 2'd0;
    cfg_delay = 5'd3;
    n = 0;
    while (cfg_valid && n < 40) begin
      #1;
      exp_r = (cyc >= e + 15);
      total++;
      if (cfg_ready !== exp_r) begin
        bad++;
        $display("FAIL blocked_ready edge %0d: got %b, required %b", cyc, cfg_ready, exp_r);
      end
      if (cfg_ready === 1'b1) begin
        model_d[0] = 3;
        tick();
        cfg_valid = 1'b0;
      end else begin
        tick();
      end
      n++;
    end
    cfg_valid = 1'b0;
    set_in(inR ^ 4'b0011);
    wait_drain("blocked");
    wait_idle("blocked");
  endtask

  task automatic test_simultaneous();
    cfg_valid  = 1'b1;
    cfg_ch     = 2'd2;
    cfg_delay  = 5'd2;
    model_d[2] = 2;
    set_in(inR ^ 4'b0100);
    #1;
    total++;
    if (cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL simul_ready: got %b, required 1", cfg_ready);
    end
    tick();
    cfg_valid = 1'b0;
    wait_drain("simul");
    wait_idle("simul");
  endtask

  task automatic test_out_of_range();
    int         e;
    logic [2:0] exp_o;
    cfg_valid3 = 1'b1;
    cfg_ch3    = 2'd3;
    cfg_delay3 = 5'd9;
    #1;
    total++;
    if (cfg_ready3 !== 1'b1) begin
      bad++;
      $display("FAIL oob_ready: got %b, required 1", cfg_ready3);
    end
    tick();
    cfg_valid3 = 1'b0;
    e = cyc + 1;
    inR3 = 3'b111;
    tick();
    while (cyc <= e + 6) begin
      exp_o = (cyc >= e + DEFD - 1) ? 3'b111 : 3'b000;
      total++;
      if (outR3 !== exp_o) begin
        bad++;
        $display("FAIL oob_outR edge %0d: got %b, required %b", cyc, outR3, exp_o);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    set_in(~inR);
    tick();
    tick();
    tick();
    rst       = 1'b1;
    inR       = '0;
    inR3      = '0;
    cfg_valid = 1'b1;
    cfg_ch    = 2'd0;
    cfg_delay = 5'd7;
    mon_en    = 1'b0;
    #1;
    total++;
    if (cfg_ready !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_ready: got %b, required 0", cfg_ready);
    end
    tick();
    for (int c = 0; c < 4; c++) begin
      exp_q[c].delete();
      model_d[c] = DEFD;
    end
    total++;
    if (outR !== 4'b0000) begin
      bad++;
      $display("FAIL rstmid_outR: got %b, required 0000", outR);
    end
    total++;
    if (busy !== 4'b0000) begin
      bad++;
      $display("FAIL rstmid_busy: got %b, required 0000", busy);
    end
    rst       = 1'b0;
    cfg_valid = 1'b0;
    mon_en    = 1'b1;
    repeat (20) begin
      tick();
      total++;
      if (busy !== 4'b0000) begin
        bad++;
        $display("FAIL rstmid_quiet_busy edge %0d: got %b, required 0000", cyc, busy);
      end
    end
    set_in(4'b1111);
    wait_drain("rstmid");
  endtask

  initial begin
    for (int c = 0; c < 4; c++) model_d[c] = DEFD;
    test_reset();
    test_program();
    test_back_to_back();
    test_blocked();
    test_simultaneous();
    test_out_of_range();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule
